jtframe_ioctl_packer: RTL and testbench
=======================================

// Module: jtframe_ioctl_packer
// PURPOSE
//  Consumes the byte stream that the MiSTer download stage puts on ioctl_* and packs it into
//  16-bit SDRAM write requests on prog_*.
//  - Works for both direct HPS writes and DDR-buffered dumps.
//  - A small byte FIFO absorbs HPS writes that arrive while SDRAM is busy.
//  - Drives dwnld_busy back to the download stage so it sees when the last byte has landed.
// PARAMETERS
//  AW      22  SDRAM word-address width of prog_addr
//  HEADER  0   leading ROM bytes discarded; ioctl_addr-HEADER is the payload byte address
//  SWAB    0   1: even byte goes to prog_data[15:8]; 0: even byte goes to prog_data[7:0]
//  FIFO_AW 3   byte FIFO depth = 2**FIFO_AW entries of {addr[26:0],data[7:0]}
// PORTS
//  clk         in   1   system clock, single domain
//  rst_n       in   1   synchronous reset, active low
//  ioctl_rom   in   1   ROM download active (level)
//  ioctl_wr    in   1   byte strobe; one byte per high cycle
//  ioctl_addr  in   27  byte address of ioctl_dout
//  ioctl_dout  in   8   byte data
//  prog_addr   out  AW  SDRAM word address
//  prog_data   out  16  write data
//  prog_mask   out  2   active-low byte enables; [0]=low byte, [1]=high byte
//  prog_we     out  1   write request, held until prog_rdy
//  prog_rdy    in   1   SDRAM write-done pulse
//  dwnld_busy  out  1   registered; high while any download byte is not yet written
//  fifo_ovf    out  1   sticky: a byte was dropped because the FIFO was full
//  oor         out  1   sticky: a byte fell outside the 2**(AW+1)-byte window
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge)
//   - All outputs go to 0 except prog_mask=2'b11.
//   - FIFO is emptied, pending byte dropped, state=IDLE.
//   - Valid mid-write: an in-flight prog_we is abandoned.
//  Input filter
//   - Only ioctl_wr && ioctl_rom bytes are taken.
//   - Bytes with ioctl_addr<HEADER are discarded silently.
//   - Bytes with payload address >= 2**(AW+1) are discarded and set oor.
//  FIFO
//   - Push on an accepted byte.
//   - Full and push: byte dropped, fifo_ovf set; contents unchanged.
//   - Push and pop in the same cycle are allowed at any occupancy.
//  Sticky clearing: the ioctl_rom 0->1 edge clears fifo_ovf and oor. It never clears the FIFO.
//  Word mapping: payload p -> word p[AW:1], lane p[0].
//   - Lane 0 is prog_data[7:0] when SWAB=0 and prog_data[15:8] when SWAB=1.
//  States: IDLE, HOLD, WRITE
//   IDLE: FIFO non-empty -> pop into the hold register, go to HOLD.
//   HOLD: one byte pending (word W, lane L).
//    - Next popped byte has word W and lane !L: merge, prog_mask=00, -> WRITE.
//    - Next popped byte has another word, or the same lane: issue the pending byte alone.
//      The new byte stays in the FIFO (not popped). Lane enabled only: 10 for lane 0,
//      01 for lane 1 (SWAB=0; swapped when SWAB=1). -> WRITE.
//    - FIFO empty and ioctl_rom=0: flush the pending byte alone -> WRITE.
//    - FIFO empty and ioctl_rom=1: stay in HOLD.
//   WRITE: prog_we=1 with addr/data/mask stable.
//    - prog_rdy: prog_we=0 on the next edge; -> HOLD if a byte was left pending, else IDLE.
//    - No pop during WRITE. prog_rdy while prog_we=0 is ignored.
//  Latency
//   - From an empty FIFO in IDLE, even byte then odd byte of the same word, 1 cycle apart:
//     prog_we rises exactly 2 cycles after the odd byte's ioctl_wr.
//   - Throughput: one word per prog_rdy plus 1 cycle.
//  dwnld_busy (registered, 1-cycle lag) = ioctl_rom | FIFO non-empty | state!=IDLE.
//   - Falls only after the last prog_rdy once ioctl_rom is low.
//  Idle flush: on ioctl_rom 1->0 with an odd-length tail, the tail byte is written with a
//   single-lane mask before dwnld_busy falls.
// TESTING
//  - Bytes 0x11@0, 0x22@1 (HEADER=0, SWAB=0)
//    -> one write: addr 0, data 16'h2211, mask 00, prog_we 2 cycles after the second byte.
//  - HEADER=4; bytes @0..5 = 00..05 -> bytes @0..3 dropped; one write: addr 0, data 16'h0504.
//  - 3-byte ROM 0xAA,0xBB,0xCC, then ioctl_rom low
//    -> writes {addr0,16'hBBAA,00} and {addr1,lo=CC,mask 10};
//       dwnld_busy falls 1 cycle after the second prog_rdy.
//  - prog_rdy held off 40 cycles while HPS pushes 10 bytes with FIFO_AW=3
//    -> bytes beyond FIFO capacity dropped, fifo_ovf=1; fifo_ovf cleared by the next ioctl_rom rise.
//  - Non-sequential bytes @6 then @9 -> two single-lane writes:
//    addr 3 mask 10, then addr 4 mask 01.
//  - rst_n low while prog_we=1 -> next edge: prog_we=0, dwnld_busy=0, FIFO empty; no write after release.

Source files
------------

// File: rtl/jtframe_ioctl_packer_if.sv
// Download-side bus of jtframe_ioctl_packer: ioctl byte stream in, prog SDRAM writes out.
// The download stage is the master; the packer takes the slave view.
interface jtframe_ioctl_packer_if #(
    parameter int AW = 22
);
    logic          ioctl_rom;
    logic          ioctl_wr;
    logic [26:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic [1:0]    prog_mask;
    logic          prog_we;
    logic          prog_rdy;
    logic          dwnld_busy;
    logic          fifo_ovf;
    logic          oor;

    modport master (
        output ioctl_rom, ioctl_wr, ioctl_addr, ioctl_dout, prog_rdy,
        input  prog_addr, prog_data, prog_mask, prog_we, dwnld_busy, fifo_ovf, oor
    );

    modport slave (
        input  ioctl_rom, ioctl_wr, ioctl_addr, ioctl_dout, prog_rdy,
        output prog_addr, prog_data, prog_mask, prog_we, dwnld_busy, fifo_ovf, oor
    );
endinterface

// File: rtl/jtframe_ioctl_packer.sv
// Packs the MiSTer ioctl byte stream into 16-bit SDRAM writes, with a small byte FIFO
// absorbing bytes that arrive while a write is outstanding.
module jtframe_ioctl_packer #(
    parameter int AW      = 22,
    parameter int HEADER  = 0,
    parameter bit SWAB    = 1'b0,
    parameter int FIFO_AW = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jtframe_ioctl_packer_if.slave io
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] { IDLE, HOLD, WRITE } state_t;
    state_t state, state_nx;

    logic [26:0]      payload;
    logic             in_hdr, out_rng, take, accept, push, pop, drop;
    logic             empty, full, rom_rise, load_hold;
    logic [34:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic [26:0]      head_p, hold_p;
    logic [7:0]       head_d, hold_d, lane0_b, lane1_b;
    logic             lane_hi;
    logic             rom_l;
    logic [AW-1:0]    addr_r, addr_nx;
    logic [15:0]      data_r, data_nx;
    logic [1:0]       mask_r, mask_nx;
    logic             we_r, we_nx;
    logic             busy_r, ovf_r, oor_r;

    generate
        if (HEADER > 0) begin : g_hdr
            assign in_hdr = io.ioctl_addr < 27'(HEADER);
        end else begin : g_nohdr
            assign in_hdr = 1'b0;
        end
    endgenerate

    assign payload  = io.ioctl_addr - 27'(HEADER);
    assign out_rng  = (payload >> (AW + 1)) != '0;
    assign take     = io.ioctl_wr && io.ioctl_rom && !in_hdr;
    assign accept   = take && !out_rng;
    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    assign push     = accept && (!full || pop);
    assign drop     = accept && full && !pop;
    assign rom_rise = io.ioctl_rom && !rom_l;
    assign {head_p, head_d} = mem[rd_ptr[FIFO_AW-1:0]];

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        load_hold = 1'b0;
        we_nx     = we_r;
        addr_nx   = addr_r;
        data_nx   = data_r;
        mask_nx   = mask_r;
        lane0_b   = hold_p[0] ? head_d : hold_d;
        lane1_b   = hold_p[0] ? hold_d : head_d;
        lane_hi   = hold_p[0] ^ SWAB;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    load_hold = 1'b1;
                    state_nx  = HOLD;
                end
            end
            HOLD: begin
                if (!empty && head_p[26:1] == hold_p[26:1] && head_p[0] != hold_p[0]) begin
                    pop      = 1'b1;
                    state_nx = WRITE;
                    we_nx    = 1'b1;
                    addr_nx  = hold_p[AW:1];
                    data_nx  = SWAB ? {lane0_b, lane1_b} : {lane1_b, lane0_b};
                    mask_nx  = 2'b00;
                end else if (!empty || !io.ioctl_rom) begin
                    // Unpairable head byte stays queued; the pending byte goes out alone
                    state_nx = WRITE;
                    we_nx    = 1'b1;
                    addr_nx  = hold_p[AW:1];
                    data_nx  = lane_hi ? {hold_d, 8'h00} : {8'h00, hold_d};
                    mask_nx  = lane_hi ? 2'b01 : 2'b10;
                end
            end
            WRITE: begin
                if (io.prog_rdy) begin
                    we_nx    = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {payload, io.ioctl_dout};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold_p <= '0;
            hold_d <= '0;
            we_r   <= 1'b0;
            addr_r <= '0;
            data_r <= '0;
            mask_r <= '1;
            rom_l  <= 1'b0;
            busy_r <= 1'b0;
            ovf_r  <= 1'b0;
            oor_r  <= 1'b0;
        end else begin
            state  <= state_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (load_hold) begin
                hold_p <= head_p;
                hold_d <= head_d;
            end
            we_r   <= we_nx;
            addr_r <= addr_nx;
            data_r <= data_nx;
            mask_r <= mask_nx;
            rom_l  <= io.ioctl_rom;
            busy_r <= io.ioctl_rom || !empty || (state != IDLE);
            if (drop) ovf_r <= 1'b1;
            else if (rom_rise) ovf_r <= 1'b0;
            if (take && out_rng) oor_r <= 1'b1;
            else if (rom_rise) oor_r <= 1'b0;
        end
    end

    assign io.prog_addr  = addr_r;
    assign io.prog_data  = data_r;
    assign io.prog_mask  = mask_r;
    assign io.prog_we    = we_r;
    assign io.dwnld_busy = busy_r;
    assign io.fifo_ovf   = ovf_r;
    assign io.oor        = oor_r;
endmodule

// File: tb/tb_jtframe_ioctl_packer.sv
// Scoreboard bench for jtframe_ioctl_packer: u0 (HEADER=0, SWAB=0) and u1 (HEADER=4, SWAB=0).
module tb_jtframe_ioctl_packer;
    typedef struct packed {
        logic [21:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jtframe_ioctl_packer_if #(.AW(22)) ifc0 ();
    jtframe_ioctl_packer_if #(.AW(22)) ifc1 ();

    jtframe_ioctl_packer #(.AW(22), .HEADER(0), .SWAB(1'b0), .FIFO_AW(3)) u0 (
        .clk(clk), .rst_n(rst_n), .io(ifc0));
    jtframe_ioctl_packer #(.AW(22), .HEADER(4), .SWAB(1'b0), .FIFO_AW(3)) u1 (
        .clk(clk), .rst_n(rst_n), .io(ifc1));

    int n_checks = 0;
    int n_fail = 0;
    wr_t exp_q[$];
    wr_t got_q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want $finish before it");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rom(input int which, input logic v);
        if (which == 0) ifc0.ioctl_rom = v;
        else ifc1.ioctl_rom = v;
    endtask

    task automatic send_byte(input int which, input logic [26:0] a, input logic [7:0] d);
        if (which == 0) begin
            ifc0.ioctl_wr = 1'b1; ifc0.ioctl_addr = a; ifc0.ioctl_dout = d;
        end else begin
            ifc1.ioctl_wr = 1'b1; ifc1.ioctl_addr = a; ifc1.ioctl_dout = d;
        end
        tick();
        ifc0.ioctl_wr = 1'b0;
        ifc1.ioctl_wr = 1'b0;
    endtask

    // Waits (bounded) for prog_we, records the request, acknowledges after delay cycles
    task automatic serve_write(input int which, input int delay, output bit ok);
        wr_t w;
        logic we;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            we = (which == 0) ? ifc0.prog_we : ifc1.prog_we;
            if (we === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) return;
        w.addr = (which == 0) ? ifc0.prog_addr : ifc1.prog_addr;
        w.data = (which == 0) ? ifc0.prog_data : ifc1.prog_data;
        w.mask = (which == 0) ? ifc0.prog_mask : ifc1.prog_mask;
        got_q.push_back(w);
        repeat (delay) tick();
        if (which == 0) ifc0.prog_rdy = 1'b1; else ifc1.prog_rdy = 1'b1;
        tick();
        ifc0.prog_rdy = 1'b0;
        ifc1.prog_rdy = 1'b0;
    endtask

    task automatic test_reset();
        ifc0.ioctl_rom = 0; ifc0.ioctl_wr = 0; ifc0.ioctl_addr = '0; ifc0.ioctl_dout = '0; ifc0.prog_rdy = 0;
        ifc1.ioctl_rom = 0; ifc1.ioctl_wr = 0; ifc1.ioctl_addr = '0; ifc1.ioctl_dout = '0; ifc1.prog_rdy = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({ifc0.prog_we, ifc0.dwnld_busy, ifc0.fifo_ovf, ifc0.oor} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got we/busy/ovf/oor=%b want 0000",
                     {ifc0.prog_we, ifc0.dwnld_busy, ifc0.fifo_ovf, ifc0.oor});
        end
        n_checks++;
        if (ifc0.prog_mask !== 2'b11) begin
            n_fail++; $display("FAIL reset_mask: got %b want 11", ifc0.prog_mask);
        end
        n_checks++;
        if (ifc0.prog_addr !== 22'd0 || ifc0.prog_data !== 16'd0) begin
            n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", ifc0.prog_addr, ifc0.prog_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pair();
        bit ok;
        wr_t e, g;
        logic [15:0] em;
        set_rom(0, 1); tick();
        send_byte(0, 27'd0, 8'h11);
        send_byte(0, 27'd1, 8'h22);
        exp_q.push_back('{addr: 22'd0, data: 16'h2211, mask: 2'b00});
        n_checks++;
        if (ifc0.prog_we !== 1'b0) begin
            n_fail++; $display("FAIL pair_early_we: got %b want 0 one cycle after odd byte", ifc0.prog_we);
        end
        tick();
        n_checks++;
        if (ifc0.prog_we !== 1'b1) begin
            n_fail++; $display("FAIL pair_latency: got prog_we=%b want 1 two cycles after odd byte", ifc0.prog_we);
        end
        serve_write(0, 2, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL pair_timeout: got no prog_we want 1 write"); end
        n_checks++;
        if (ifc0.prog_we !== 1'b0) begin
            n_fail++; $display("FAIL pair_we_drop: got %b want 0 after prog_rdy", ifc0.prog_we);
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            em = {{8{~e.mask[1]}}, {8{~e.mask[0]}}};
            n_checks++;
            if (g.addr !== e.addr || g.mask !== e.mask || (g.data & em) !== (e.data & em)) begin
                n_fail++;
                $display("FAIL pair_write: got addr=%h data=%h mask=%b want addr=%h data=%h mask=%b",
                         g.addr, g.data, g.mask, e.addr, e.data, e.mask);
            end
        end
        set_rom(0, 0);
        for (int i = 0; i < 20 && ifc0.dwnld_busy !== 1'b0; i++) tick();
        n_checks++;
        if (ifc0.dwnld_busy !== 1'b0) begin n_fail++; $display("FAIL pair_busy: got 1 want 0"); end
    endtask

    task automatic test_header();
        bit ok;
        wr_t e, g;
        logic [15:0] em;
        set_rom(1, 1); tick();
        for (int i = 0; i < 6; i++) send_byte(1, 27'(i), 8'(i));
        exp_q.push_back('{addr: 22'd0, data: 16'h0504, mask: 2'b00});
        serve_write(1, 0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL header_timeout: got no prog_we want 1 write"); end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            em = {{8{~e.mask[1]}}, {8{~e.mask[0]}}};
            n_checks++;
            if (g.addr !== e.addr || g.mask !== e.mask || (g.data & em) !== (e.data & em)) begin
                n_fail++;
                $display("FAIL header_write: got addr=%h data=%h mask=%b want addr=%h data=%h mask=%b",
                         g.addr, g.data, g.mask, e.addr, e.data, e.mask);
            end
        end
        set_rom(1, 0);
        for (int i = 0; i < 20 && ifc1.dwnld_busy !== 1'b0; i++) tick();
        n_checks++;
        if (ifc1.dwnld_busy !== 1'b0 || ifc1.prog_we !== 1'b0 || ifc1.oor !== 1'b0) begin
            n_fail++; $display("FAIL header_idle: got busy/we/oor=%b%b%b want 000",
                               ifc1.dwnld_busy, ifc1.prog_we, ifc1.oor);
        end
    endtask

    task automatic test_tail();
        bit ok;
        wr_t e, g;
        logic [15:0] em;
        set_rom(0, 1); tick();
        send_byte(0, 27'd0, 8'hAA);
        send_byte(0, 27'd1, 8'hBB);
        send_byte(0, 27'd2, 8'hCC);
        set_rom(0, 0);
        exp_q.push_back('{addr: 22'd0, data: 16'hBBAA, mask: 2'b00});
        exp_q.push_back('{addr: 22'd1, data: 16'h00CC, mask: 2'b10});
        for (int i = 0; i < 2; i++) begin
            serve_write(0, 2, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL tail_timeout: got no write %0d want 2 writes", i); end
        end
        n_checks++;
        if (ifc0.dwnld_busy !== 1'b1) begin
            n_fail++; $display("FAIL tail_busy_lag: got %b want 1 on the cycle after prog_rdy", ifc0.dwnld_busy);
        end
        tick();
        n_checks++;
        if (ifc0.dwnld_busy !== 1'b0) begin
            n_fail++; $display("FAIL tail_busy_fall: got %b want 0", ifc0.dwnld_busy);
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            em = {{8{~e.mask[1]}}, {8{~e.mask[0]}}};
            n_checks++;
            if (g.addr !== e.addr || g.mask !== e.mask || (g.data & em) !== (e.data & em)) begin
                n_fail++;
                $display("FAIL tail_write: got addr=%h data=%h mask=%b want addr=%h data=%h mask=%b",
                         g.addr, g.data, g.mask, e.addr, e.data, e.mask);
            end
        end
    endtask

    task automatic test_nonseq();
        bit ok;
        wr_t e, g;
        logic [15:0] em;
        set_rom(0, 1); tick();
        send_byte(0, 27'd6, 8'h66);
        send_byte(0, 27'd9, 8'h99);
        exp_q.push_back('{addr: 22'd3, data: 16'h0066, mask: 2'b10});
        serve_write(0, 1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL nonseq_timeout1: got no prog_we want write"); end
        repeat (5) tick();
        n_checks++;
        if (ifc0.prog_we !== 1'b0 || ifc0.dwnld_busy !== 1'b1) begin
            n_fail++; $display("FAIL nonseq_hold: got we/busy=%b%b want 01 while rom high",
                               ifc0.prog_we, ifc0.dwnld_busy);
        end
        set_rom(0, 0);
        exp_q.push_back('{addr: 22'd4, data: 16'h9900, mask: 2'b01});
        serve_write(0, 0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL nonseq_timeout2: got no flush want write"); end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            em = {{8{~e.mask[1]}}, {8{~e.mask[0]}}};
            n_checks++;
            if (g.addr !== e.addr || g.mask !== e.mask || (g.data & em) !== (e.data & em)) begin
                n_fail++;
                $display("FAIL nonseq_write: got addr=%h data=%h mask=%b want addr=%h data=%h mask=%b",
                         g.addr, g.data, g.mask, e.addr, e.data, e.mask);
            end
        end
        for (int i = 0; i < 20 && ifc0.dwnld_busy !== 1'b0; i++) tick();
    endtask

    task automatic test_overflow();
        bit ok;
        wr_t e, g;
        logic [15:0] em;
        set_rom(0, 1); tick();
        send_byte(0, 27'd0, 8'hA0);
        send_byte(0, 27'd1, 8'hA1);
        tick();
        // The write above is held off; 8 of these 10 bytes fit, the last 2 are dropped
        for (int i = 2; i < 12; i++) send_byte(0, 27'(i), 8'hA0 + 8'(i));
        n_checks++;
        if (ifc0.fifo_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ifc0.fifo_ovf); end
        repeat (28) tick();
        for (int w = 0; w < 5; w++)
            exp_q.push_back('{addr: 22'(w), data: {8'hA1 + 8'(2*w), 8'hA0 + 8'(2*w)}, mask: 2'b00});
        for (int i = 0; i < 5; i++) begin
            serve_write(0, 0, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL ovf_timeout: got no write %0d want 5 writes", i); end
        end
        set_rom(0, 0);
        for (int i = 0; i < 20 && ifc0.dwnld_busy !== 1'b0; i++) tick();
        n_checks++;
        if (ifc0.dwnld_busy !== 1'b0 || ifc0.prog_we !== 1'b0) begin
            n_fail++; $display("FAIL ovf_extra_write: got busy/we=%b%b want 00", ifc0.dwnld_busy, ifc0.prog_we);
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            em = {{8{~e.mask[1]}}, {8{~e.mask[0]}}};
            n_checks++;
            if (g.addr !== e.addr || g.mask !== e.mask || (g.data & em) !== (e.data & em)) begin
                n_fail++;
                $display("FAIL ovf_write: got addr=%h data=%h mask=%b want addr=%h data=%h mask=%b",
                         g.addr, g.data, g.mask, e.addr, e.data, e.mask);
            end
        end
        n_checks++;
        if (ifc0.fifo_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ifc0.fifo_ovf); end
        set_rom(0, 1); tick();
        n_checks++;
        if (ifc0.fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ifc0.fifo_ovf); end
        set_rom(0, 0);
        for (int i = 0; i < 20 && ifc0.dwnld_busy !== 1'b0; i++) tick();
    endtask

    task automatic test_oor();
        bit ok;
        wr_t e, g;
        logic [15:0] em;
        set_rom(0, 1); tick();
        send_byte(0, 27'h0800000, 8'h5A);
        n_checks++;
        if (ifc0.oor !== 1'b1) begin n_fail++; $display("FAIL oor_set: got %b want 1", ifc0.oor); end
        send_byte(0, 27'h07FFFFF, 8'h7F);
        set_rom(0, 0);
        exp_q.push_back('{addr: 22'h3FFFFF, data: 16'h7F00, mask: 2'b01});
        serve_write(0, 0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL oor_timeout: got no write want top-byte write"); end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            em = {{8{~e.mask[1]}}, {8{~e.mask[0]}}};
            n_checks++;
            if (g.addr !== e.addr || g.mask !== e.mask || (g.data & em) !== (e.data & em)) begin
                n_fail++;
                $display("FAIL oor_write: got addr=%h data=%h mask=%b want addr=%h data=%h mask=%b",
                         g.addr, g.data, g.mask, e.addr, e.data, e.mask);
            end
        end
        for (int i = 0; i < 20 && ifc0.dwnld_busy !== 1'b0; i++) tick();
        n_checks++;
        if (ifc0.oor !== 1'b1 || ifc0.prog_we !== 1'b0) begin
            n_fail++; $display("FAIL oor_sticky: got oor/we=%b%b want 10", ifc0.oor, ifc0.prog_we);
        end
        set_rom(0, 1); tick();
        n_checks++;
        if (ifc0.oor !== 1'b0) begin n_fail++; $display("FAIL oor_clear: got %b want 0", ifc0.oor); end
        set_rom(0, 0);
        for (int i = 0; i < 20 && ifc0.dwnld_busy !== 1'b0; i++) tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        wr_t e, g;
        logic [15:0] em;
        set_rom(0, 1); tick();
        for (int i = 0; i < 8; i++) send_byte(0, 27'h100 + 27'(i), 8'h30 + 8'(i));
        for (int w = 0; w < 4; w++)
            exp_q.push_back('{addr: 22'h80 + 22'(w), data: {8'h31 + 8'(2*w), 8'h30 + 8'(2*w)}, mask: 2'b00});
        for (int i = 0; i < 4; i++) begin
            serve_write(0, 0, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got no write %0d want 4 writes", i); end
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            em = {{8{~e.mask[1]}}, {8{~e.mask[0]}}};
            n_checks++;
            if (g.addr !== e.addr || g.mask !== e.mask || (g.data & em) !== (e.data & em)) begin
                n_fail++;
                $display("FAIL b2b_write: got addr=%h data=%h mask=%b want addr=%h data=%h mask=%b",
                         g.addr, g.data, g.mask, e.addr, e.data, e.mask);
            end
        end
        set_rom(0, 0);
        for (int i = 0; i < 20 && ifc0.dwnld_busy !== 1'b0; i++) tick();
        n_checks++;
        if (ifc0.dwnld_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got 1 want 0"); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        set_rom(0, 1); tick();
        for (int i = 0; i < 4; i++) send_byte(0, 27'h40 + 27'(i), 8'hE0 + 8'(i));
        n_checks++;
        if (ifc0.prog_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_we: got %b want 1 before reset", ifc0.prog_we); end
        rst_n = 1'b0;
        set_rom(0, 0);
        tick();
        n_checks++;
        if (ifc0.prog_we !== 1'b0 || ifc0.dwnld_busy !== 1'b0 || ifc0.prog_mask !== 2'b11) begin
            n_fail++; $display("FAIL rstmid_abandon: got we/busy/mask=%b%b%b want 0011",
                               ifc0.prog_we, ifc0.dwnld_busy, ifc0.prog_mask);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ifc0.prog_we !== 1'b0 || ifc0.dwnld_busy !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL rstmid_leftover: got activity after release want none"); end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_header();
        test_tail();
        test_nonseq();
        test_overflow();
        test_oor();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
